env_render_scanner: RTL and testbench

//  Reader side of the environment location-register grid: walks every cell in raster order, drives the render

---
 rtl/env_render_scanner_pkg.sv | 22 ++
 rtl/env_render_scanner_fifo.sv | 42 ++++
 rtl/env_render_scanner.sv | 150 +++++++++++++++
 tb/tb_env_render_scanner.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/env_render_scanner_pkg.sv
// Shared sizing and types for the environment render scanner.
// Default grid is 16x16 cells of SIGNAL_BITS+1 bit location words.
package env_pkg;

   localparam int SIGNAL_BITS = 8;
   localparam int N           = SIGNAL_BITS + 1;
   localparam int GRID_W      = 16;
   localparam int GRID_H      = 16;
   localparam int XW          = $clog2(GRID_W);
   localparam int YW          = $clog2(GRID_H);

   typedef logic [N-1:0]  cell_t;
   typedef logic [XW-1:0] coord_x_t;
   typedef logic [YW-1:0] coord_y_t;

   typedef enum logic [1:0] {
      SCAN_IDLE  = 2'd0,
      SCAN_ISSUE = 2'd1,
      SCAN_DRAIN = 2'd2
   } scan_state_t;

endpackage

// File: rtl/env_render_scanner_fifo.sv
// Two-entry skid FIFO holding sampled cell words with their coordinates.
// Head is read straight from storage; push and pop in the same cycle are allowed even when full.
module render_skid_fifo #(
   parameter int W = 8
) (
   input  logic         Clk,
   input  logic         Clr,
   input  logic         push,
   input  logic [W-1:0] wr_data,
   input  logic         pop,
   output logic [W-1:0] rd_data,
   output logic [1:0]   count
);

   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;

   always_ff @(posedge Clk) begin
      if (Clr) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            mem[i] <= '0;
         end
      end else begin
         // When full, wr_ptr == rd_ptr: a simultaneous push overwrites the slot being popped.
         if (push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/env_render_scanner.sv
// Raster-order reader of the location grid: issues render selects, samples the bus a cycle later, streams cells out.
// Issue is throttled so FIFO plus in-flight never exceeds two; RENDER_CHECKSUM_EN adds the Frame_Sum output.
module env_render_scanner #(
   parameter int N      = env_pkg::N,
   parameter int GRID_W = env_pkg::GRID_W,
   parameter int GRID_H = env_pkg::GRID_H,
   localparam int XW    = $clog2(GRID_W),
   localparam int YW    = $clog2(GRID_H)
) (
   input  logic          Clk,
   input  logic          Clr,
   input  logic          Start,
   output logic          Render_En,
   output logic [XW-1:0] Render_X,
   output logic [YW-1:0] Render_Y,
   input  logic [N-1:0]  Render_Data_In,
   output logic          Pix_Valid,
   input  logic          Pix_Ready,
   output logic [N-1:0]  Pix_Data,
   output logic [XW-1:0] Pix_X,
   output logic [YW-1:0] Pix_Y,
   output logic          Pix_Last,
   output logic          Busy,
   output logic          Frame_Done
`ifdef RENDER_CHECKSUM_EN
   ,
   output logic [15:0]   Frame_Sum
`endif
);

   import env_pkg::*;

   localparam int EW = N + XW + YW + 1;

   scan_state_t   state;
   scan_state_t   state_nxt;
   logic [XW-1:0] addr_x;
   logic [YW-1:0] addr_y;
   logic [XW-1:0] iss_x;
   logic [YW-1:0] iss_y;
   logic          iss_last;
   logic          inflight;
   logic          addr_last;
   logic          accept;
   logic          start_go;
   logic          done_set;
   logic [1:0]    fifo_count;
   logic [1:0]    occ;
   logic [EW-1:0] push_data;
   logic [EW-1:0] head_data;

   assign addr_last = (addr_x == XW'(GRID_W - 1)) && (addr_y == YW'(GRID_H - 1));
   assign accept    = Pix_Valid && Pix_Ready;
   // Slots committed after this edge if nothing new is issued; a same-cycle accept frees one.
   assign occ       = fifo_count + {1'b0, inflight} - {1'b0, accept};
   assign Busy      = (state != SCAN_IDLE);
   assign Render_X  = addr_x;
   assign Render_Y  = addr_y;

   always_comb begin
      state_nxt = state;
      Render_En = 1'b0;
      start_go  = 1'b0;
      done_set  = 1'b0;
      case (state)
         SCAN_IDLE: begin
            if (Start && !Frame_Done) begin
               start_go  = 1'b1;
               state_nxt = SCAN_ISSUE;
            end
         end
         SCAN_ISSUE: begin
            if (occ < 2'd2) begin
               Render_En = 1'b1;
               if (addr_last) begin
                  state_nxt = SCAN_DRAIN;
               end
            end
         end
         SCAN_DRAIN: begin
            if (accept && Pix_Last) begin
               done_set  = 1'b1;
               state_nxt = SCAN_IDLE;
            end
         end
         default: state_nxt = SCAN_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Clr) begin
         state      <= SCAN_IDLE;
         addr_x     <= '0;
         addr_y     <= '0;
         iss_x      <= '0;
         iss_y      <= '0;
         iss_last   <= 1'b0;
         inflight   <= 1'b0;
         Frame_Done <= 1'b0;
      end else begin
         state      <= state_nxt;
         Frame_Done <= done_set;
         inflight   <= Render_En;
         if (Render_En) begin
            iss_x    <= addr_x;
            iss_y    <= addr_y;
            iss_last <= addr_last;
            // The last issue wraps both counters, so the next frame starts at (0,0).
            if (addr_x == XW'(GRID_W - 1)) begin
               addr_x <= '0;
               addr_y <= addr_last ? '0 : addr_y + 1'b1;
            end else begin
               addr_x <= addr_x + 1'b1;
            end
         end
      end
   end

   assign push_data = {Render_Data_In, iss_x, iss_y, iss_last};

   render_skid_fifo #(
      .W(EW)
   ) u_fifo (
      .Clk     (Clk),
      .Clr     (Clr),
      .push    (inflight),
      .wr_data (push_data),
      .pop     (accept),
      .rd_data (head_data),
      .count   (fifo_count)
   );

   assign Pix_Valid = (fifo_count != 2'd0);
   assign {Pix_Data, Pix_X, Pix_Y, Pix_Last} = head_data;

`ifdef RENDER_CHECKSUM_EN
   localparam int SW = (N < 16) ? N : 16;

   always_ff @(posedge Clk) begin
      if (Clr) begin
         Frame_Sum <= '0;
      end else if (start_go) begin
         Frame_Sum <= '0;
      end else if (accept) begin
         Frame_Sum <= Frame_Sum + 16'(Pix_Data[SW-1:0]);
      end
   end
`endif

endmodule

// File: tb/tb_env_render_scanner.sv
// Bench for env_render_scanner: table of frame scenarios with random bus contents and consumer stalls,
// plus hand-written hold, mid-frame clear and restart sequences.
module tb_env_render_scanner;

   import env_pkg::*;

   localparam int CELLS = GRID_W * GRID_H;

   logic     Clk            = 1'b0;
   logic     Clr            = 1'b1;
   logic     Start          = 1'b0;
   logic     Pix_Ready      = 1'b0;
   cell_t    Render_Data_In = '0;
   logic     Render_En;
   coord_x_t Render_X;
   coord_y_t Render_Y;
   logic     Pix_Valid;
   cell_t    Pix_Data;
   coord_x_t Pix_X;
   coord_y_t Pix_Y;
   logic     Pix_Last;
   logic     Busy;
   logic     Frame_Done;
`ifdef RENDER_CHECKSUM_EN
   logic [15:0] Frame_Sum;
`endif

   env_render_scanner dut (
      .Clk            (Clk),
      .Clr            (Clr),
      .Start          (Start),
      .Render_En      (Render_En),
      .Render_X       (Render_X),
      .Render_Y       (Render_Y),
      .Render_Data_In (Render_Data_In),
      .Pix_Valid      (Pix_Valid),
      .Pix_Ready      (Pix_Ready),
      .Pix_Data       (Pix_Data),
      .Pix_X          (Pix_X),
      .Pix_Y          (Pix_Y),
      .Pix_Last       (Pix_Last),
      .Busy           (Busy),
      .Frame_Done     (Frame_Done)
`ifdef RENDER_CHECKSUM_EN
      ,
      .Frame_Sum      (Frame_Sum)
`endif
   );

   always #5 Clk = ~Clk;

   typedef struct {
      cell_t d;
      int    x;
      int    y;
      logic  last;
   } beat_t;

   typedef struct {
      string name;
      int    rmode;      // consumer pattern
      int    bmode;      // 0: cell(x,y)=y*16+x, 1: random contents
      int    smode;      // 0: none, 1: random mid-frame Start, 2: Start alongside Frame_Done
      int    exp_first;  // step of first Pix_Valid (Start is step 0)
      int    exp_done;   // step of Frame_Done, -1 when the consumer stalls randomly
   } vec_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   cell_t       mem [CELLS];
   beat_t       got [$];
   logic        bus_pend = 1'b0;
   int          bus_x = 0;
   int          bus_y = 0;
   int          step_no = 0;
   int          en_cnt = 0;
   int          done_cnt = 0;
   int          first_valid = -1;
   int          done_step = -1;
   logic        busy_at_done = 1'b1;
   logic        start_on_done = 1'b0;
   logic        prev_stall = 1'b0;
   beat_t       prev_beat;
   logic [15:0] sum_at_done = '0;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One clock: drive inputs after the falling edge, observe 1 time unit later, wait for the next falling edge.
   task automatic step(input logic rdy, input logic st, input logic clr);
      Pix_Ready      = rdy;
      Start          = st || (start_on_done && Frame_Done);
      Clr            = clr;
      Render_Data_In = bus_pend ? mem[bus_y * GRID_W + bus_x] : cell_t'($urandom);
      #1;
      if (prev_stall)
         check("stall_hold", (Pix_Valid && Pix_Data === prev_beat.d && int'(Pix_X) == prev_beat.x &&
                              int'(Pix_Y) == prev_beat.y && Pix_Last === prev_beat.last) ? 1 : 0, 1);
      if (Render_En) en_cnt++;
      bus_pend = Render_En && !clr;
      bus_x    = int'(Render_X);
      bus_y    = int'(Render_Y);
      if (Pix_Valid && first_valid < 0) first_valid = step_no;
      if (Pix_Valid && rdy && !clr) got.push_back('{Pix_Data, int'(Pix_X), int'(Pix_Y), Pix_Last});
      if (Frame_Done) begin
         done_cnt++;
         if (done_step < 0) begin
            done_step    = step_no;
            busy_at_done = Busy;
`ifdef RENDER_CHECKSUM_EN
            sum_at_done  = Frame_Sum;
`endif
         end
      end
      prev_stall = Pix_Valid && !rdy && !clr;
      prev_beat  = '{Pix_Data, int'(Pix_X), int'(Pix_Y), Pix_Last};
      step_no++;
      @(negedge Clk);
   endtask

   function automatic logic pick_ready(input int mode, input int s);
      case (mode)
         0:       return 1'b1;
         1:       return (s % 2 == 0);
         2:       return 1'($urandom_range(0, 1));
         3:       return ($urandom_range(0, 3) == 0);
         default: return 1'b1;
      endcase
   endfunction

   task automatic fill_mem(input int bmode);
      for (int y = 0; y < GRID_H; y++)
         for (int x = 0; x < GRID_W; x++)
            mem[y * GRID_W + x] = (bmode == 0) ? cell_t'(y * 16 + x) : cell_t'($urandom);
   endtask

   function automatic logic [15:0] model_sum();
      logic [15:0] s = '0;
      for (int i = 0; i < CELLS; i++) s = s + 16'(mem[i]);
      return s;
   endfunction

   task automatic begin_frame(input logic rdy);
      got.delete();
      en_cnt       = 0;
      done_cnt     = 0;
      first_valid  = -1;
      done_step    = -1;
      busy_at_done = 1'b1;
      step_no      = 0;
      step(rdy, 1'b1, 1'b0);
   endtask

   task automatic continue_frame(input int rmode, input int smode, input int clr_at);
      logic clr;
      while (done_cnt == 0 && step_no < 6000) begin
         clr = (clr_at >= 0) && (got.size() >= clr_at);
         step(pick_ready(rmode, step_no), (smode == 1) && ($urandom_range(0, 15) == 0), clr);
         if (clr) return;
      end
      if (done_cnt == 0) check("frame_done_timeout", 0, 1);
   endtask

   // Expected frame: every cell once, raster order x-fastest, word unmodified, Last only on the final cell.
   task automatic check_stream(input string tag);
      int errs = 0;
      check({tag, "_accepts"}, got.size(), CELLS);
      for (int y = 0; y < GRID_H; y++) begin
         for (int x = 0; x < GRID_W; x++) begin
            int k;
            k = y * GRID_W + x;
            if (k >= got.size()) errs++;
            else if (got[k].d !== mem[k] || got[k].x != x || got[k].y != y ||
                     got[k].last !== (x == GRID_W - 1 && y == GRID_H - 1)) errs++;
         end
      end
      check({tag, "_stream"}, errs, 0);
      check({tag, "_render_en_pulses"}, en_cnt, CELLS);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [5];
      // With Pix_Ready high: Start sampled at the edge closing step 0, Pix_Valid two edges later (step 3),
      // one accept per step 3..258, Frame_Done the step after the last accept.
      vecs[0] = '{"ready_hi_coord",   0, 0, 0, 3, 259};
      vecs[1] = '{"toggle_coord",     1, 0, 0, 3, -1};
      vecs[2] = '{"rand_ready",       2, 1, 0, 3, -1};
      vecs[3] = '{"sparse_midstart",  3, 1, 1, 3, -1};
      vecs[4] = '{"start_with_done",  0, 1, 2, 3, 259};

      @(negedge Clk);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      check("rst_render_en", Render_En, 0);
      check("rst_render_xy", {Render_X, Render_Y}, 0);
      check("rst_pix_valid", Pix_Valid, 0);
      check("rst_pix_word", {Pix_Data, Pix_X, Pix_Y, Pix_Last}, 0);
      check("rst_busy", Busy, 0);
      check("rst_frame_done", Frame_Done, 0);
`ifdef RENDER_CHECKSUM_EN
      check("rst_frame_sum", Frame_Sum, 0);
`endif

      for (int i = 0; i < 5; i++) begin
         fill_mem(vecs[i].bmode);
         start_on_done = (vecs[i].smode == 2);
         begin_frame(pick_ready(vecs[i].rmode, 0));
         continue_frame(vecs[i].rmode, vecs[i].smode, -1);
         check_stream(vecs[i].name);
         check({vecs[i].name, "_first_valid"}, first_valid, vecs[i].exp_first);
         if (vecs[i].exp_done >= 0) check({vecs[i].name, "_done_step"}, done_step, vecs[i].exp_done);
         check({vecs[i].name, "_busy_at_done"}, busy_at_done, 0);
         start_on_done = 1'b0;
         repeat (3) step(1'b1, 1'b0, 1'b0);
         check({vecs[i].name, "_idle_busy"}, Busy, 0);
         check({vecs[i].name, "_done_pulses"}, done_cnt, 1);
         check({vecs[i].name, "_no_extra_issue"}, en_cnt, CELLS);
`ifdef RENDER_CHECKSUM_EN
         check({vecs[i].name, "_frame_sum"}, sum_at_done, (vecs[i].bmode == 0) ? 16'h7F80 : model_sum());
         check({vecs[i].name, "_frame_sum_hold"}, Frame_Sum, sum_at_done);
`endif
      end

      // Consumer never ready: only two reads issued, FIFO holds (0,0) then (1,0).
      fill_mem(1);
      begin_frame(1'b0);
      repeat (11) step(1'b0, 1'b0, 1'b0);
      check("hold_render_en_pulses", en_cnt, 2);
      check("hold_head_valid", Pix_Valid, 1);
      check("hold_head0_xy", {Pix_X, Pix_Y}, 0);
      check("hold_head0_data", Pix_Data, mem[0]);
      step(1'b1, 1'b0, 1'b0);
      check("hold_head1_x", Pix_X, 1);
      check("hold_head1_y", Pix_Y, 0);
      check("hold_head1_data", Pix_Data, mem[1]);
      continue_frame(0, 0, -1);
      check_stream("hold_release");

      // Clear after 100 cells, then a fresh Start must scan the whole grid from (0,0).
      repeat (2) step(1'b1, 1'b0, 1'b0);
      fill_mem(1);
      begin_frame(1'b1);
      continue_frame(0, 0, 100);
      check("clr_busy", Busy, 0);
      check("clr_pix_valid", Pix_Valid, 0);
      check("clr_render_en", Render_En, 0);
      check("clr_frame_done", Frame_Done, 0);
`ifdef RENDER_CHECKSUM_EN
      check("clr_frame_sum", Frame_Sum, 0);
`endif
      begin_frame(1'b1);
      continue_frame(2, 0, -1);
      check_stream("restart");
      check("restart_done_pulses", done_cnt, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
